quad_step_decoder: RTL and testbench

//   Upstream front end for the up/down/set counter. Takes a raw two-phase

---
 rtl/quad_step_decoder_pkg.sv | 35 +++
 rtl/quad_step_decoder_debounce_filter.sv | 57 +++++
 rtl/quad_step_decoder.sv | 138 +++++++++++++
 tb/tb_quad_step_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_step_decoder_pkg.sv
// Shared types for the quadrature front end: Gray pair, FSM phase and step decode.
// Pure combinational helpers with no latency and no flow control.
package quad_pkg;

  typedef logic [1:0] gray_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    FWD     = 2'd1,
    REV     = 2'd2,
    ILLEGAL = 2'd3
  } dir_t;

  // Position along the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(gray_t g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  function automatic dir_t step_dir(gray_t prev, gray_t cur);
    logic [1:0] delta;
    delta = gray_pos(cur) - gray_pos(prev);
    case (delta)
      2'd0:    return NONE;
      2'd1:    return FWD;
      2'd3:    return REV;
      default: return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_debounce_filter.sv
// One encoder channel: 2-FF synchroniser then a run-length debounce on the synced bit.
// Raw-to-sync 2 cycles, sync-to-filtered DEBOUNCE cycles; no backpressure.
module debounce_filter
  import quad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic prime,
  output logic sync,
  output logic filt
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] run_q, run_d;

  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    filt_d = filt_q;
    run_d  = '0;
    if (prime) begin
      filt_d = sync_q;
    end else if (sync_q != filt_q) begin
      // run_q counts differing cycles already seen; this cycle completes the run
      if (run_q == CW'(DEBOUNCE - 1)) begin
        filt_d = sync_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign sync = sync_q;
  assign filt = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: debounced Gray steps become up/down/err pulses, presets become set pulses.
// Step pulse 1 cycle after filtered change; a preset waits out any coincident step, preset_ready low until the cycle after set.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEBOUNCE  = 4,
  parameter int PRIME_CYC = DEBOUNCE + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             preset_valid,
  input  logic [CNT_W-1:0] preset_value,
  output logic             preset_ready,
  output logic             up,
  output logic             down,
  output logic             set,
  output logic [CNT_W-1:0] set_value,
  output logic             err
);

  localparam int PW = $clog2(PRIME_CYC + 1);

  gray_t            sync_ab;
  gray_t            filt_ab;
  logic             priming;
  logic             hs;
  logic             pend;
  dir_t             dir;

  phase_t           phase_q, phase_d;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  gray_t            prev_q, prev_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             err_q, err_d;
  logic             set_q, set_d;
  logic [CNT_W-1:0] set_value_q, set_value_d;
  logic             held_vld_q, held_vld_d;
  logic [CNT_W-1:0] held_val_q, held_val_d;

  assign priming = (phase_q == PRIME);

  debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_flt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_a),
    .prime (priming),
    .sync  (sync_ab[1]),
    .filt  (filt_ab[1])
  );

  debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_flt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_b),
    .prime (priming),
    .sync  (sync_ab[0]),
    .filt  (filt_ab[0])
  );

  // held_vld_q covers both the waiting period and the set cycle itself
  assign preset_ready = !held_vld_q && !reset;
  assign hs           = preset_valid && preset_ready;

  always_comb begin
    phase_d     = phase_q;
    prime_cnt_d = prime_cnt_q;
    prev_d      = prev_q;
    dir         = NONE;
    up_d        = 1'b0;
    down_d      = 1'b0;
    err_d       = 1'b0;
    if (phase_q == PRIME) begin
      prime_cnt_d = prime_cnt_q + 1'b1;
      if (prime_cnt_q == PW'(PRIME_CYC - 1)) begin
        // filters load sync on this same edge, so prev starts equal to filtered
        phase_d = RUN;
        prev_d  = sync_ab;
      end
    end else begin
      dir    = step_dir(prev_q, filt_ab);
      prev_d = filt_ab;
      up_d   = (dir == FWD);
      down_d = (dir == REV);
      err_d  = (dir == ILLEGAL);
    end

    pend        = (held_vld_q && !set_q) || hs;
    set_d       = pend && !up_d && !down_d;
    set_value_d = set_value_q;
    if (set_d) begin
      set_value_d = hs ? preset_value : held_val_q;
    end
    held_val_d = hs ? preset_value : held_val_q;
    held_vld_d = held_vld_q;
    if (set_q) begin
      held_vld_d = 1'b0;
    end else if (hs) begin
      held_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PRIME;
      prime_cnt_q <= '0;
      prev_q      <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      err_q       <= 1'b0;
      set_q       <= 1'b0;
      set_value_q <= '0;
      held_vld_q  <= 1'b0;
      held_val_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      prime_cnt_q <= prime_cnt_d;
      prev_q      <= prev_d;
      up_q        <= up_d;
      down_q      <= down_d;
      err_q       <= err_d;
      set_q       <= set_d;
      set_value_q <= set_value_d;
      held_vld_q  <= held_vld_d;
      held_val_q  <= held_val_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign err       = err_q;
  assign set       = set_q;
  assign set_value = set_value_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random encoder/preset traffic against a cycle model.
module tb_quad_step_decoder;

  localparam int CNT_W     = 8;
  localparam int DEBOUNCE  = 4;
  localparam int PRIME_CYC = DEBOUNCE + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enc_a;
  logic             enc_b;
  logic             preset_valid;
  logic [CNT_W-1:0] preset_value;
  logic             preset_ready;
  logic             up;
  logic             down;
  logic             set;
  logic [CNT_W-1:0] set_value;
  logic             err;

  always #5 clk = ~clk;

  quad_step_decoder #(.CNT_W(CNT_W), .DEBOUNCE(DEBOUNCE)) dut (
    .clk          (clk),
    .reset        (reset),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .preset_valid (preset_valid),
    .preset_value (preset_value),
    .preset_ready (preset_ready),
    .up           (up),
    .down         (down),
    .set          (set),
    .set_value    (set_value),
    .err          (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: sync = raw two samples back, debounce by run length,
  // step direction from positions on the 00,01,11,10 ring.
  int               since    = 0;
  logic [1:0]       raw_h1   = 2'b00;
  logic [1:0]       raw_h2   = 2'b00;
  logic [1:0]       filt_m   = 2'b00;
  logic [1:0]       prev_m   = 2'b00;
  int               run_m [2];
  logic             up_e     = 1'b0;
  logic             down_e   = 1'b0;
  logic             err_e    = 1'b0;
  logic             set_e    = 1'b0;
  logic [CNT_W-1:0] setv_e   = '0;
  logic             waiting  = 1'b0;
  logic [CNT_W-1:0] wait_val = '0;
  int               pos_tab [4] = '{0, 1, 3, 2};

  int               n_up   = 0;
  int               n_down = 0;
  int               n_err  = 0;
  int               n_set  = 0;
  logic [CNT_W-1:0] ctr    = '0;

  task automatic model_edge();
    logic [1:0] raw_now;
    logic [1:0] sync_seen;
    logic [1:0] old_filt;
    logic       hs;
    int         d;
    raw_now = {enc_a, enc_b};
    hs      = preset_valid && !reset && !waiting && !set_e;
    if (reset) begin
      since    = 0;
      filt_m   = 2'b00;
      prev_m   = 2'b00;
      run_m[0] = 0;
      run_m[1] = 0;
      up_e     = 1'b0;
      down_e   = 1'b0;
      err_e    = 1'b0;
      set_e    = 1'b0;
      setv_e   = '0;
      waiting  = 1'b0;
      raw_h2   = raw_h1;
      raw_h1   = raw_now;
      return;
    end
    if (since < 100000) since++;
    sync_seen = (since >= 3) ? raw_h2 : 2'b00;
    raw_h2    = raw_h1;
    raw_h1    = raw_now;
    old_filt  = filt_m;
    up_e      = 1'b0;
    down_e    = 1'b0;
    err_e     = 1'b0;
    if (since <= PRIME_CYC) begin
      filt_m   = sync_seen;
      run_m[0] = 0;
      run_m[1] = 0;
      if (since == PRIME_CYC) prev_m = sync_seen;
    end else begin
      d      = (pos_tab[old_filt] - pos_tab[prev_m] + 4) % 4;
      up_e   = (d == 1);
      down_e = (d == 3);
      err_e  = (d == 2);
      prev_m = old_filt;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_seen[ch] == filt_m[ch]) begin
          run_m[ch] = 0;
        end else begin
          run_m[ch]++;
          if (run_m[ch] == DEBOUNCE) begin
            filt_m[ch] = sync_seen[ch];
            run_m[ch]  = 0;
          end
        end
      end
    end
    if (hs) begin
      waiting  = 1'b1;
      wait_val = preset_value;
    end
    set_e = 1'b0;
    if (waiting && !up_e && !down_e) begin
      set_e   = 1'b1;
      setv_e  = wait_val;
      waiting = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    check("preset_ready", 32'(preset_ready), 32'(!reset && !waiting && !set_e));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("up", 32'(up), 32'(up_e));
    check("down", 32'(down), 32'(down_e));
    check("err", 32'(err), 32'(err_e));
    check("set", 32'(set), 32'(set_e));
    check("set_value", 32'(set_value), 32'(setv_e));
    if (up) n_up++;
    if (down) n_down++;
    if (err) n_err++;
    if (set) n_set++;
    if (set) ctr = set_value;
    else if (up) ctr = ctr + 1'b1;
    else if (down) ctr = ctr - 1'b1;
  endtask

  task automatic clear_counts();
    n_up   = 0;
    n_down = 0;
    n_err  = 0;
    n_set  = 0;
  endtask

  task automatic hold_enc(input logic [1:0] g, input int n);
    {enc_a, enc_b} = g;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [1:0] g);
    {enc_a, enc_b} = g;
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("rst_outputs", 32'({up, down, err, set}), 32'd0);
      check("rst_set_value", 32'(set_value), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(preset_ready), 32'd1);
  endtask

  task automatic rand_hold(input logic [1:0] g, input int n);
    {enc_a, enc_b} = g;
    repeat (n) begin
      preset_valid = ($urandom_range(0, 3) == 0);
      preset_value = CNT_W'($urandom);
      tick();
    end
  endtask

  initial begin
    int         kind;
    int         glen;
    logic [1:0] cur;
    logic [1:0] nxt;

    reset        = 1'b1;
    enc_a        = 1'b1;
    enc_b        = 1'b1;
    preset_valid = 1'b0;
    preset_value = '0;

    // 1: reset with encoder static at 11
    do_reset(2'b11);
    clear_counts();
    repeat (20) tick();
    check("t1_no_up", 32'(n_up), 32'd0);
    check("t1_no_down", 32'(n_down), 32'd0);
    check("t1_no_err", 32'(n_err), 32'd0);

    // 2: forward then reverse cycles
    do_reset(2'b00);
    repeat (PRIME_CYC + 4) tick();
    clear_counts();
    hold_enc(2'b01, 10);
    hold_enc(2'b11, 10);
    hold_enc(2'b10, 10);
    hold_enc(2'b00, 10);
    check("t2_fwd_up", 32'(n_up), 32'd4);
    check("t2_fwd_down", 32'(n_down), 32'd0);
    check("t2_fwd_err", 32'(n_err), 32'd0);
    clear_counts();
    hold_enc(2'b10, 10);
    hold_enc(2'b11, 10);
    hold_enc(2'b01, 10);
    hold_enc(2'b00, 10);
    check("t2_rev_down", 32'(n_down), 32'd4);
    check("t2_rev_up", 32'(n_up), 32'd0);

    // 3: short glitch on A is filtered, a held change is one step
    clear_counts();
    hold_enc(2'b10, 2);
    hold_enc(2'b00, 12);
    check("t3_glitch_steps", 32'(n_up + n_down + n_err), 32'd0);
    clear_counts();
    hold_enc(2'b10, 14);
    check("t3_hold_down", 32'(n_down), 32'd1);
    check("t3_hold_up", 32'(n_up + n_err), 32'd0);

    // 4: double-bit jump, then prev resynced
    hold_enc(2'b00, 12);
    clear_counts();
    hold_enc(2'b11, 12);
    check("t4_err", 32'(n_err), 32'd1);
    check("t4_err_nostep", 32'(n_up + n_down), 32'd0);
    clear_counts();
    hold_enc(2'b10, 12);
    check("t4_resync_up", 32'(n_up), 32'd1);

    // 5: preset arrives on the same edge a step pulse is produced
    hold_enc(2'b00, 6);
    preset_valid = 1'b1;
    preset_value = 8'd8;
    tick();
    check("t5_up_first", 32'(up), 32'd1);
    check("t5_no_set_with_up", 32'(set), 32'd0);
    preset_valid = 1'b0;
    tick();
    check("t5_set", 32'(set), 32'd1);
    check("t5_set_value", 32'(set_value), 32'd8);
    tick();
    check("t5_counter", 32'(ctr), 32'd8);
    hold_enc(2'b00, 4);

    // 6: reset while a preset is held back by a step
    hold_enc(2'b01, 6);
    preset_valid = 1'b1;
    preset_value = 8'hA5;
    tick();
    check("t6_up", 32'(up), 32'd1);
    preset_valid = 1'b0;
    clear_counts();
    do_reset(2'b01);
    repeat (12) tick();
    check("t6_no_set", 32'(n_set), 32'd0);
    check("t6_set_value", 32'(set_value), 32'd0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      cur  = {enc_a, enc_b};
      if (kind == 0) begin
        rand_hold(cur ^ 2'b11, $urandom_range(1, 12));
      end else if (kind == 1) begin
        glen = $urandom_range(1, DEBOUNCE + 1);
        nxt  = cur ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        rand_hold(nxt, glen);
        rand_hold(cur, $urandom_range(DEBOUNCE + 2, 12));
      end else if (kind == 2 && $urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        rand_hold(cur, 2);
        reset = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1)
          nxt = 2'(pos_tab[(pos_tab[cur] + 1) % 4]);
        else
          nxt = 2'(pos_tab[(pos_tab[cur] + 3) % 4]);
        rand_hold(nxt, $urandom_range(1, 12));
      end
    end
    preset_valid = 1'b0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
